// File: rtl/difftest_pkg.sv
// Shared types for the difftest commit queue: commit record layout and
// the tracking FSM states.
package difftest_pkg;

    localparam int XLEN_DEF   = 64;
    localparam int NR_GPR_DEF = 32;
    localparam int GPR_IDX_W  = $clog2(NR_GPR_DEF);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED,
        ST_HUNG
    } state_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0]  pc;
        logic [31:0]          inst;
        logic                 wen;
        logic [GPR_IDX_W-1:0] wdest;
        logic [XLEN_DEF-1:0]  wdata;
        logic                 skip;
        logic                 trap;
        logic [XLEN_DEF-1:0]  trap_code;
    } commit_t;

endpackage

// File: rtl/difftest_fifo.sv
// Generic DEPTH-entry FIFO of commit records with full/empty flags.
// Pushes while full and pops while empty are ignored.
module difftest_fifo
    import difftest_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = commit_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push_valid,
    input  T     i_push_data,
    input  logic i_pop_ready,
    output T     o_pop_data,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    T               r_mem [DEPTH];
    logic [AW:0]    r_wptr;
    logic [AW:0]    r_rptr;
    logic           w_push;
    logic           w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty    = (r_wptr == r_rptr);
    assign w_push     = i_push_valid && !o_full;
    assign w_pop      = i_pop_ready && !o_empty;
    assign o_pop_data = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_push_data;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/difftest_commit_queue.sv
// Commit-tracking stage feeding the difftest checker: buffers retired records,
// advances a shadow GPR file per consumed record, and detects halt and hang.
module difftest_commit_queue
    import difftest_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int NR_GPR  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmt_valid,
    output logic                      cmt_ready,
    input  logic [XLEN-1:0]           cmt_pc,
    input  logic [31:0]               cmt_inst,
    input  logic                      cmt_wen,
    input  logic [$clog2(NR_GPR)-1:0] cmt_wdest,
    input  logic [XLEN-1:0]           cmt_wdata,
    input  logic                      cmt_skip,
    input  logic                      cmt_trap,
    input  logic [XLEN-1:0]           cmt_trap_code,
    output logic                      chk_valid,
    input  logic                      chk_ready,
    output logic [XLEN-1:0]           chk_pc,
    output logic [31:0]               chk_inst,
    output logic                      chk_skip,
    output logic                      chk_trap,
    output logic [XLEN-1:0]           chk_trap_code,
    output logic [63:0]               chk_seq,
    output logic [NR_GPR*XLEN-1:0]    chk_gpr,
    output logic                      halted,
    output logic                      hung
);

    localparam int GW  = $clog2(NR_GPR);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            wen;
        logic [GW-1:0]   wdest;
        logic [XLEN-1:0] wdata;
        logic            skip;
        logic            trap;
        logic [XLEN-1:0] trap_code;
    } rec_t;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [WDW-1:0]  r_wdog;
    logic [63:0]     r_seq;
    logic [XLEN-1:0] r_shadow [NR_GPR];

    rec_t            w_tail;
    rec_t            w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_enq;
    logic            w_deq;
    logic            w_overlay;

    assign w_tail = '{pc: cmt_pc, inst: cmt_inst, wen: cmt_wen, wdest: cmt_wdest,
                      wdata: cmt_wdata, skip: cmt_skip, trap: cmt_trap,
                      trap_code: cmt_trap_code};

    difftest_fifo #(
        .DEPTH (DEPTH),
        .T     (rec_t)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push_valid (w_enq),
        .i_push_data  (w_tail),
        .i_pop_ready  (w_deq),
        .o_pop_data   (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    assign cmt_ready     = !w_full && (r_state == ST_RUN);
    assign chk_valid     = !w_empty && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
    assign w_enq         = cmt_valid && cmt_ready;
    assign w_deq         = chk_valid && chk_ready;
    assign w_overlay     = chk_valid && w_head.wen;

    assign chk_pc        = w_head.pc;
    assign chk_inst      = w_head.inst;
    assign chk_skip      = w_head.skip;
    assign chk_trap      = w_head.trap;
    assign chk_trap_code = w_head.trap_code;
    assign chk_seq       = r_seq;
    assign halted        = (r_state == ST_HALTED);
    assign hung          = (r_state == ST_HUNG);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_enq && cmt_trap) begin
                    w_state_nxt = ST_DRAIN;
                end else if (!w_enq && (r_wdog == WD_MAX)) begin
                    w_state_nxt = ST_HUNG;
                end
            end
            ST_DRAIN: begin
                if (w_deq && w_head.trap) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_wdog  <= '0;
            r_seq   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_RUN) begin
                if (w_enq) begin
                    r_wdog <= '0;
                end else if (r_wdog != WD_MAX) begin
                    r_wdog <= r_wdog + 1'b1;
                end
            end
            if (w_deq) begin
                r_seq <= r_seq + 64'd1;
            end
        end
    end

    // Entry 0 is never written, so it stays zero from reset onward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_GPR; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_deq && w_head.wen && (w_head.wdest != '0)) begin
            r_shadow[w_head.wdest] <= w_head.wdata;
        end
    end

    // Checker sees the state after the head commit, so overlay its pending write.
    always_comb begin
        chk_gpr = '0;
        for (int i = 1; i < NR_GPR; i++) begin
            chk_gpr[i*XLEN +: XLEN] = r_shadow[i];
            if (w_overlay && (w_head.wdest == GW'(i))) begin
                chk_gpr[i*XLEN +: XLEN] = w_head.wdata;
            end
        end
    end

endmodule
